// File: rtl/mul_ucode_sequencer_if.sv
// rtl/mul_ucode_sequencer_if.sv - decoder <-> multiply sequencer request/writeback bundle
interface mul_ucode_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             mul_trigger;
  logic [1:0]       mul_type;
  logic [3:0]       dest_reg;
  logic [WIDTH-1:0] src_a_data;
  logic [WIDTH-1:0] src_b_data;
  logic [15:0]      imm;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             rf_we;
  logic [3:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             done;
  logic             overflow;

  modport master (
    output mul_trigger, mul_type, dest_reg, src_a_data, src_b_data, imm, flush,
    input  busy, stall, rf_we, rf_waddr, rf_wdata, done, overflow
  );

  modport slave (
    input  mul_trigger, mul_type, dest_reg, src_a_data, src_b_data, imm, flush,
    output busy, stall, rf_we, rf_waddr, rf_wdata, done, overflow
  );
endinterface

// File: rtl/mul_ucode_sequencer.sv
// rtl/mul_ucode_sequencer.sv - shift-add multiply sequencer with register-file writeback
// Optional MUL_EARLY_EXIT_EN: leave ITER as soon as the remaining multiplier is zero.
module mul_ucode_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  mul_ucode_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ITER, WRITE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mplier;
  logic [CNT_W-1:0]     cnt;
  logic [3:0]           dest_q;
  logic                 signed_q;
  logic                 neg_q;
  logic                 we_q;
  logic                 ovf_q;
  logic [3:0]           waddr_q;
  logic [WIDTH-1:0]     wdata_q;

  logic [WIDTH-1:0]     op_b;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mplier_nxt;
  logic [2*WIDTH-1:0]   prod;
  logic                 last_iter;
  logic                 ovf_nxt;

  always_comb begin
    op_b = '0;
    if (bus.mul_type[0])
      op_b = bus.src_b_data;
    else if (bus.mul_type[1])
      op_b = WIDTH'($signed(bus.imm));
    else
      op_b = WIDTH'(bus.imm);

    a_neg = bus.mul_type[1] & bus.src_a_data[WIDTH-1];
    b_neg = bus.mul_type[1] & op_b[WIDTH-1];
    a_mag = a_neg ? -bus.src_a_data : bus.src_a_data;
    b_mag = b_neg ? -op_b : op_b;
  end

  // The product is finalised on the edge that enters WRITE so rf_wdata is a plain register.
  always_comb begin
    acc_nxt    = mplier[0] ? (acc + mcand) : acc;
    mplier_nxt = mplier >> 1;
    prod       = neg_q ? -acc_nxt : acc_nxt;
`ifdef MUL_EARLY_EXIT_EN
    last_iter  = (cnt == CNT_W'(WIDTH - 1)) || (mplier_nxt == '0);
`else
    last_iter  = (cnt == CNT_W'(WIDTH - 1));
`endif
    if (signed_q)
      ovf_nxt = ~((&prod[2*WIDTH-1:WIDTH-1]) | ~(|prod[2*WIDTH-1:WIDTH-1]));
    else
      ovf_nxt = |acc_nxt[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      cnt      <= '0;
      dest_q   <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      we_q     <= 1'b0;
      ovf_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      we_q  <= 1'b0;
      ovf_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mul_trigger && !bus.flush) begin
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            dest_q   <= bus.dest_reg;
            signed_q <= bus.mul_type[1];
            neg_q    <= a_neg ^ b_neg;
            state    <= ITER;
          end
        end
        ITER: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier_nxt;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              state   <= WRITE;
              we_q    <= 1'b1;
              ovf_q   <= ovf_nxt;
              wdata_q <= prod[WIDTH-1:0];
              waddr_q <= dest_q;
            end
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush arriving during WRITE cancels the write in that same cycle.
  assign bus.rf_we    = we_q & ~bus.flush;
  assign bus.done     = we_q & ~bus.flush;
  assign bus.overflow = ovf_q & ~bus.flush;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.busy     = (state != IDLE);
  assign bus.stall    = rst & (((state == IDLE) & bus.mul_trigger) | (state == ITER));

endmodule

// File: tb/tb_mul_ucode_sequencer.sv
// tb/tb_mul_ucode_sequencer.sv - directed scoreboard bench for mul_ucode_sequencer
module tb_mul_ucode_sequencer;
  localparam int W = 32;
`ifdef MUL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_ucode_sequencer_if #(.WIDTH(W)) bus ();
  mul_ucode_sequencer #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_miss = 0;
  int n_writes = 0;
  logic [36:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opb(input logic [1:0] t, input logic [31:0] b, input logic [15:0] im);
    if (t[0]) return b;
    if (t[1]) return {{16{im[15]}}, im};
    return {16'h0, im};
  endfunction

  // {overflow, low word} from plain 64-bit arithmetic
  function automatic logic [32:0] model(input logic [1:0] t, input logic [31:0] a,
                                        input logic [31:0] b, input logic [15:0] im);
    logic [31:0] bv;
    longint      pa, pb, p;
    logic [63:0] pv;
    bv = opb(t, b, im);
    if (t[1]) begin
      pa = longint'($signed(a));
      pb = longint'($signed(bv));
      p  = pa * pb;
      pv = p;
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), pv[31:0]};
    end
    pv = {32'h0, a} * {32'h0, bv};
    return {|pv[63:32], pv[31:0]};
  endfunction

  function automatic int exp_latency(input logic [1:0] t, input logic [31:0] b, input logic [15:0] im);
    logic [31:0] bv;
    int k;
    bv = opb(t, b, im);
    if (t[1] && bv[31]) bv = -bv;
    k = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) k = i + 1;
    return EARLY ? k + 1 : W + 1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [36:0] e;
    if (rst === 1'b1 && bus.rf_we === 1'b1) begin
      n_writes++;
      chk("done_with_we", 64'(bus.done), 64'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("rf_waddr", 64'(bus.rf_waddr), 64'(e[36:33]));
        chk("overflow", 64'(bus.overflow), 64'(e[32]));
        chk("rf_wdata", 64'(bus.rf_wdata), 64'(e[31:0]));
      end
    end
  end

  task automatic drive(input logic trig, input logic [1:0] t, input logic [3:0] d,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
    bus.mul_trigger = trig;
    bus.mul_type    = t;
    bus.dest_reg    = d;
    bus.src_a_data  = a;
    bus.src_b_data  = b;
    bus.imm         = im;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at the start of a cycle; returns at the start of the cycle after WRITE.
  task automatic do_mul(input string tag, input logic [1:0] t, input logic [3:0] d,
                        input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                        input int retrig);
    int lat = 0;
    int stall_lo = 0;
    int w0 = n_writes;
    int exp_lat = exp_latency(t, b, im);
    drive(1'b1, t, d, a, b, im);
    exp_q.push_back({d, model(t, a, b, im)});
    @(negedge clk);
    chk({tag, "_stall_T"}, 64'(bus.stall), 64'd1);
    chk({tag, "_busy_T"}, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    drive(1'b0, ~t, ~d, $urandom, $urandom, 16'($urandom));
    for (int n = 1; n <= W + 4 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.rf_we === 1'b1) begin
        lat = n;
        chk({tag, "_stall_write"}, 64'(bus.stall), 64'd0);
        chk({tag, "_busy_write"}, 64'(bus.busy), 64'd1);
      end else if (bus.stall !== 1'b1) begin
        stall_lo++;
      end
      @(posedge clk); #1;
      bus.mul_trigger = (retrig > 0) && (n + 1 == retrig);
    end
    bus.mul_trigger = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall_iter"}, 64'(stall_lo), 64'd0);
    chk({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    if (retrig > 0) idle(W + 8);
    chk({tag, "_one_write"}, 64'(n_writes - w0), 64'd1);
  endtask

  initial begin
    int w0;
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 16'd0);
    idle(3);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_mul("muli_7x6", 2'd0, 4'd3, 32'd7, 32'd0, 16'd6, 0);
    do_mul("mulsr_m3x5", 2'd3, 4'd5, 32'hFFFF_FFFD, 32'd5, 16'd0, 0);
    do_mul("mulsi_min_x_m1", 2'd2, 4'd7, 32'h8000_0000, 32'd0, 16'hFFFF, 0);
    do_mul("mulr_ovf_retrig", 2'd1, 4'd12, 32'h0001_0000, 32'h0001_0000, 16'd0, 5);
    for (int i = 0; i < 4; i++)
      do_mul("rand", 2'($urandom), 4'($urandom), $urandom, $urandom, 16'($urandom), 0);
    do_mul("muli_3x2", 2'd0, 4'd9, 32'd3, 32'd0, 16'd2, 0);

    // flush in ITER cycle T+10
    w0 = n_writes;
    drive(1'b1, 2'd1, 4'd2, 32'd5, 32'hFFFF_FFFF, 16'd0);
    @(posedge clk); #1;
    bus.mul_trigger = 1'b0;
    idle(9);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_T10", 64'(bus.busy), 64'd1);
    chk("flush_we_T10", 64'(bus.rf_we), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_T11", 64'(bus.busy), 64'd0);
    idle(W + 4);
    chk("flush_no_write", 64'(n_writes - w0), 64'd0);

    // flush beats a simultaneous trigger in IDLE
    bus.mul_trigger = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.mul_trigger = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_trig_idle_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;

    // reset at ITER cycle T+20
    w0 = n_writes;
    drive(1'b1, 2'd1, 4'd6, 32'd9, 32'hFFFF_FFFF, 16'd0);
    @(posedge clk); #1;
    bus.mul_trigger = 1'b0;
    idle(19);
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_stall", 64'(bus.stall), 64'd0);
    chk("arst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("arst_done", 64'(bus.done), 64'd0);
    chk("arst_overflow", 64'(bus.overflow), 64'd0);
    chk("arst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("arst_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    idle(2);
    @(negedge clk); rst = 1'b1;
    idle(W + 4);
    chk("arst_no_write", 64'(n_writes - w0), 64'd0);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
